// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W    = 32;
  localparam int DEF_LINES = 16;
  localparam int DEF_WORDS = 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  function automatic int ob_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int ib_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return ADDR_W - 2 - $clog2(lines) - $clog2(words);
  endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays: one asynchronous read port, one synchronous write port.
module icache_store
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS,
  parameter int IB    = ib_w(LINES),
  parameter int OB    = ob_w(WORDS),
  parameter int TAG_W = tag_w(LINES, WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IB-1:0]    i_rd_idx,
  input  logic [OB-1:0]    i_rd_off,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [31:0]      o_rd_data,
  input  logic [IB-1:0]    i_wr_idx,
  input  logic             i_wr_en,
  input  logic [OB-1:0]    i_wr_off,
  input  logic [31:0]      i_wr_data,
  input  logic             i_set_valid,
  input  logic [TAG_W-1:0] i_set_tag,
  input  logic             i_clr_valid
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES][WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_set_valid) begin
      r_valid[i_wr_idx] <= 1'b1;
    end else if (i_clr_valid) begin
      r_valid[i_wr_idx] <= 1'b0;
    end
  end

  // NOTE: tag and data arrays carry no reset; the valid bits alone guard them,
  // which keeps these arrays mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_off] <= i_wr_data;
    end
    if (i_set_valid) begin
      r_tag[i_wr_idx] <= i_set_tag;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_off];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, in-order line refill on a miss.
module icache
  import icache_pkg::*;
#(
  parameter int LINES = DEF_LINES,
  parameter int WORDS = DEF_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        icstall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int OB    = ob_w(WORDS);
  localparam int IB    = ib_w(LINES);
  localparam int TAG_W = tag_w(LINES, WORDS);

  state_t                r_state;
  logic [TAG_W+IB-1:0]   r_fill_line;
  logic [OB-1:0]         r_wcnt;
  logic                  r_mem_req;

  logic [OB-1:0]    w_off;
  logic [IB-1:0]    w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IB-1:0]    w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic [IB-1:0]    w_line_idx;
  logic             w_rd_valid;
  logic [TAG_W-1:0] w_rd_tag;
  logic [31:0]      w_rd_data;
  logic             w_hit;
  logic             w_last;
  logic             w_wr_en;
  logic             w_set_valid;
  logic             w_clr_valid;
  logic             w_unused_pc;

  assign w_off       = pc[OB+1:2];
  assign w_idx       = pc[OB+IB+1:OB+2];
  assign w_tag       = pc[31:OB+IB+2];
  assign w_unused_pc = ^pc[1:0];

  assign w_fill_idx = r_fill_line[IB-1:0];
  assign w_fill_tag = r_fill_line[TAG_W+IB-1:IB];
  assign w_last     = (r_wcnt == OB'(WORDS - 1));

  assign w_hit = w_rd_valid && (w_rd_tag == w_tag);

  // Writes target the fill line during FILL, and the missing pc's line on the FILL-entry clear.
  assign w_line_idx  = (r_state == FILL) ? w_fill_idx : w_idx;
  assign w_wr_en     = (r_state == FILL) && mem_ready && !reset;
  assign w_set_valid = w_wr_en && w_last;
  assign w_clr_valid = (r_state == IDLE) && !w_hit && !reset;

  icache_store #(
    .LINES (LINES),
    .WORDS (WORDS),
    .IB    (IB),
    .OB    (OB),
    .TAG_W (TAG_W)
  ) u_store (
    .clk         (clk),
    .reset       (reset),
    .i_rd_idx    (w_idx),
    .i_rd_off    (w_off),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_idx    (w_line_idx),
    .i_wr_en     (w_wr_en),
    .i_wr_off    (r_wcnt),
    .i_wr_data   (mem_rdata),
    .i_set_valid (w_set_valid),
    .i_set_tag   (w_fill_tag),
    .i_clr_valid (w_clr_valid)
  );

  // NOTE: all state here updates with non-blocking assignments so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_mem_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_hit) begin
            r_fill_line <= {w_tag, w_idx};
            r_wcnt      <= '0;
            r_mem_req   <= 1'b1;
            r_state     <= FILL;
          end
        end
        FILL: begin
          if (mem_ready) begin
            r_wcnt <= r_wcnt + OB'(1);
            if (w_last) begin
              r_mem_req <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
      endcase
    end
  end

  assign icstall  = (r_state == FILL) || !w_hit;
  assign instr    = icstall ? 32'h0 : w_rd_data;
  assign mem_req  = r_mem_req;
  assign mem_addr = {r_fill_line, r_wcnt, 2'b00};

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold fill, conflict, wait states, pc change, reset abort, idle ready.
module tb_icache;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        icstall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        junk;

  int n_checks = 0;
  int n_errors = 0;
  int stalls;

  icache #(.LINES(16), .WORDS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .icstall   (icstall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word n holds n; junk mode returns a marker to expose stray writes.
  assign mem_rdata = junk ? 32'hDEAD_BEEF : {2'b00, mem_addr[31:2]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs from the current low phase until icstall drops; ready on every period-th cycle.
  task automatic run_fill(input logic [31:0] base, input int period, input bit chk_addr,
                          output int n_stall);
    int  c;
    int  w;
    bit  done;
    c = 0;
    w = 0;
    done = 1'b0;
    n_stall = 0;
    while (!done) begin
      mem_ready = (period == 1) || (c > 0 && (c % period) == 0);
      #1;
      if (!icstall) begin
        done = 1'b1;
      end else begin
        n_stall++;
        if (chk_addr && mem_req) begin
          check("fill_addr", mem_addr, base + 32'(4 * w));
          if (mem_ready) w++;
        end
        c++;
        if (c > 200) begin
          check("fill_timeout", 32'(c), 32'd0);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    mem_ready = 1'b0;
    if (chk_addr) check("fill_words", 32'(w), 32'd4);
  endtask

  task automatic hit_at(input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    pc = a;
    #1;
    check("hit_stall", {31'b0, icstall}, 32'd0);
    check("hit_instr", instr, exp);
  endtask

  initial begin
    reset = 1'b1;
    pc = 32'h0;
    mem_ready = 1'b0;
    junk = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_stall", {31'b0, icstall}, 32'd1);
    check("rst_instr", instr, 32'h0);

    // Cold start
    reset = 1'b0;
    pc = 32'h0;
    run_fill(32'h0, 1, 1'b1, stalls);
    check("cold_stalls", 32'(stalls), 32'd5);
    check("cold_instr", instr, 32'h0);
    hit_at(32'h8, 32'd2);
    hit_at(32'h4, 32'd1);
    hit_at(32'hC, 32'd3);

    // Conflict miss on index 0
    @(negedge clk);
    pc = 32'h100;
    run_fill(32'h100, 1, 1'b1, stalls);
    check("conf_stalls", 32'(stalls), 32'd5);
    check("conf_instr", instr, 32'h40);
    @(negedge clk);
    pc = 32'h0;
    run_fill(32'h0, 1, 1'b1, stalls);
    check("conf_back_stalls", 32'(stalls), 32'd5);
    check("conf_back_instr", instr, 32'h0);

    // Wait states: ready every third cycle
    @(negedge clk);
    pc = 32'h40;
    run_fill(32'h40, 3, 1'b1, stalls);
    check("wait_stalls", 32'(stalls), 32'd13);
    check("wait_instr", instr, 32'h10);
    hit_at(32'h4C, 32'h13);

    // pc changes on the second FILL cycle
    @(negedge clk);
    pc = 32'h20;
    mem_ready = 1'b1;
    #1;
    check("pcchg_miss", {31'b0, icstall}, 32'd1);
    @(negedge clk);
    #1;
    check("pcchg_addr0", mem_addr, 32'h20);
    @(negedge clk);
    pc = 32'h60;
    #1;
    check("pcchg_addr1", mem_addr, 32'h24);
    run_fill(32'h60, 1, 1'b0, stalls);
    check("pcchg_stalls", 32'(stalls), 32'd8);
    check("pcchg_instr", instr, 32'h18);
    hit_at(32'h20, 32'h8);
    hit_at(32'h2C, 32'hB);

    // Reset on the third FILL cycle of 0x80
    @(negedge clk);
    pc = 32'h80;
    mem_ready = 1'b1;
    #1;
    check("rstfill_miss", {31'b0, icstall}, 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstfill_addr", mem_addr, 32'h88);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("rstfill_req", {31'b0, mem_req}, 32'd0);
    check("rstfill_stall", {31'b0, icstall}, 32'd1);
    run_fill(32'h80, 1, 1'b1, stalls);
    check("rstfill_stalls", 32'(stalls), 32'd5);
    check("rstfill_instr", instr, 32'h20);

    // mem_ready pulses while idle on a hit
    @(negedge clk);
    pc = 32'h84;
    junk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0] ? 1'b0 : 1'b1;
      #1;
      check("idle_instr", instr, 32'h21);
      check("idle_req", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check("idle_instr_last", instr, 32'h21);
    mem_ready = 1'b0;
    junk = 1'b0;
    hit_at(32'h80, 32'h20);
    hit_at(32'h8C, 32'h23);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
